// File: rtl/if_id_stage_if.sv
// rtl/if_id_stage_if.sv - fetch/decode boundary signals of the IF/ID stage
interface if_id_stage_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] pc_in;
  logic [WIDTH-1:0] instr_in;
  logic             stall;
  logic             flush;
  logic             pc_ce;
  logic [WIDTH-1:0] id_pc_plus1;
  logic [WIDTH-1:0] id_instr;
  logic             id_valid;
  logic [15:0]      fetch_count;

  modport master (
    output pc_in, instr_in, stall, flush,
    input  pc_ce, id_pc_plus1, id_instr, id_valid, fetch_count
  );

  modport slave (
    input  pc_in, instr_in, stall, flush,
    output pc_ce, id_pc_plus1, id_instr, id_valid, fetch_count
  );
endinterface

// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - fetch-to-decode pipeline register with stall, flush and bubble drain
module if_id_stage #(
  parameter int                WIDTH         = 16,
  parameter logic [WIDTH-1:0]  NOP           = '0,
  parameter int unsigned       FLUSH_BUBBLES = 1
) (
  input  logic          clk,
  input  logic          rst,
  if_id_stage_if.slave  bus
);

  typedef enum logic {
    RUN      = 1'b0,
    FLUSHING = 1'b1
  } state_e;

  localparam logic [3:0]       RELOAD = 4'(FLUSH_BUBBLES - 1);
  localparam logic [WIDTH-1:0] ONE    = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           state_q;
  logic [3:0]       bubble_cnt_q;
  logic [WIDTH-1:0] id_instr_q;
  logic [WIDTH-1:0] id_pc_plus1_q;
  logic             id_valid_q;
  logic [15:0]      fetch_count_q;
  logic [WIDTH-1:0] pc_plus1_d;

  assign pc_plus1_d = bus.pc_in + ONE;

  // While bubbles drain the PC stays parked on the redirect target.
  assign bus.pc_ce = (state_q == RUN) ? (bus.flush | ~bus.stall) : bus.flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      bubble_cnt_q  <= 4'd0;
      id_instr_q    <= NOP;
      id_pc_plus1_q <= '0;
      id_valid_q    <= 1'b0;
      fetch_count_q <= 16'd0;
    end else if (bus.flush) begin
      id_instr_q    <= NOP;
      id_pc_plus1_q <= '0;
      id_valid_q    <= 1'b0;
      if (FLUSH_BUBBLES == 1) begin
        state_q      <= RUN;
        bubble_cnt_q <= 4'd0;
      end else begin
        state_q      <= FLUSHING;
        bubble_cnt_q <= RELOAD;
      end
    end else if (!bus.stall) begin
      case (state_q)
        RUN: begin
          id_instr_q    <= bus.instr_in;
          id_pc_plus1_q <= pc_plus1_d;
          id_valid_q    <= 1'b1;
          fetch_count_q <= fetch_count_q + 16'd1;
        end
        FLUSHING: begin
          id_instr_q   <= NOP;
          id_valid_q   <= 1'b0;
          bubble_cnt_q <= bubble_cnt_q - 4'd1;
          if (bubble_cnt_q <= 4'd1) begin
            state_q <= RUN;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign bus.id_instr    = id_instr_q;
  assign bus.id_pc_plus1 = id_pc_plus1_q;
  assign bus.id_valid    = id_valid_q;
  assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - bench for if_id_stage at three bubble depths against a cycle model
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc, instr;
  logic        stall, flush;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_id_stage_if #(.WIDTH(16)) b0 ();
  if_id_stage_if #(.WIDTH(16)) b1 ();
  if_id_stage_if #(.WIDTH(16)) b2 ();

  assign b0.pc_in = pc;  assign b0.instr_in = instr;  assign b0.stall = stall;  assign b0.flush = flush;
  assign b1.pc_in = pc;  assign b1.instr_in = instr;  assign b1.stall = stall;  assign b1.flush = flush;
  assign b2.pc_in = pc;  assign b2.instr_in = instr;  assign b2.stall = stall;  assign b2.flush = flush;

  if_id_stage #(.WIDTH(16), .NOP(16'h0000), .FLUSH_BUBBLES(1)) u0 (.clk(clk), .rst(rst), .bus(b0));
  if_id_stage #(.WIDTH(16), .NOP(16'hF00D), .FLUSH_BUBBLES(3)) u1 (.clk(clk), .rst(rst), .bus(b1));
  if_id_stage #(.WIDTH(16), .NOP(16'hDEAD), .FLUSH_BUBBLES(4)) u2 (.clk(clk), .rst(rst), .bus(b2));

  logic [15:0] o_instr [3];
  logic [15:0] o_pc    [3];
  logic        o_valid [3];
  logic [15:0] o_cnt   [3];
  logic        o_pcce  [3];

  assign o_instr[0] = b0.id_instr;    assign o_instr[1] = b1.id_instr;    assign o_instr[2] = b2.id_instr;
  assign o_pc[0]    = b0.id_pc_plus1; assign o_pc[1]    = b1.id_pc_plus1; assign o_pc[2]    = b2.id_pc_plus1;
  assign o_valid[0] = b0.id_valid;    assign o_valid[1] = b1.id_valid;    assign o_valid[2] = b2.id_valid;
  assign o_cnt[0]   = b0.fetch_count; assign o_cnt[1]   = b1.fetch_count; assign o_cnt[2]   = b2.fetch_count;
  assign o_pcce[0]  = b0.pc_ce;       assign o_pcce[1]  = b1.pc_ce;       assign o_pcce[2]  = b2.pc_ce;

  // Model: per instance, what decode should see and how many bubbles are still owed.
  int          nb      [3] = '{1, 3, 4};
  logic [15:0] nop     [3] = '{16'h0000, 16'hF00D, 16'hDEAD};
  logic [15:0] m_instr [3];
  int          m_pc    [3];
  bit          m_valid [3];
  int          m_cnt   [3];
  int          m_rem   [3];

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[u%0d] observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_instr[k] = nop[k]; m_pc[k] = 0; m_valid[k] = 0; m_cnt[k] = 0; m_rem[k] = 0;
      end else if (flush) begin
        m_instr[k] = nop[k]; m_pc[k] = 0; m_valid[k] = 0; m_rem[k] = nb[k] - 1;
      end else if (stall) begin
        // everything frozen
      end else if (m_rem[k] > 0) begin
        m_rem[k]--; m_instr[k] = nop[k]; m_valid[k] = 0;
      end else begin
        m_instr[k] = instr;
        m_pc[k]    = (int'(pc) + 1) % 65536;
        m_valid[k] = 1;
        m_cnt[k]   = (m_cnt[k] + 1) % 65536;
      end
    end
  endtask

  task automatic cycle(input bit do_check);
    bit exp_ce;
    @(negedge clk);
    if (do_check && !rst) begin
      for (int k = 0; k < 3; k++) begin
        exp_ce = (m_rem[k] > 0) ? flush : (flush | ~stall);
        chk("pc_ce", k, 32'(o_pcce[k]), 32'(exp_ce));
      end
    end
    @(posedge clk);
    model_edge();
    #1;
    if (do_check) begin
      for (int k = 0; k < 3; k++) begin
        chk("id_instr", k, 32'(o_instr[k]), 32'(m_instr[k]));
        chk("id_pc_plus1", k, 32'(o_pc[k]), 32'(m_pc[k]));
        chk("id_valid", k, 32'(o_valid[k]), 32'(m_valid[k]));
        chk("fetch_count", k, 32'(o_cnt[k]), 32'(m_cnt[k]));
      end
    end
  endtask

  task automatic drive(input logic r, input logic [15:0] p, input logic [15:0] i,
                       input logic s, input logic f);
    rst = r; pc = p; instr = i; stall = s; flush = f;
    cycle(1'b1);
  endtask

  initial begin
    rst = 1'b1; pc = '0; instr = '0; stall = 1'b0; flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      m_instr[k] = nop[k]; m_pc[k] = 0; m_valid[k] = 0; m_cnt[k] = 0; m_rem[k] = 0;
    end

    // Reset then run
    drive(1, 16'h0000, 16'h0000, 0, 0);
    drive(1, 16'h0000, 16'h0000, 0, 0);
    drive(0, 16'h0010, 16'h1234, 0, 0);
    chk("first_capture", 0, 32'(o_instr[0]), 32'h1234);
    chk("first_pc", 0, 32'(o_pc[0]), 32'h0011);
    chk("first_count", 0, 32'(o_cnt[0]), 32'd1);

    // Stall hold and release
    drive(0, 16'h0020, 16'hABCD, 0, 0);
    for (int n = 0; n < 3; n++) drive(0, 16'h0021, 16'h5555, 1, 0);
    chk("stall_hold", 1, 32'(o_instr[1]), 32'hABCD);
    drive(0, 16'h0021, 16'h5555, 0, 0);

    // Flush pulse, then drain
    drive(0, 16'h0022, 16'h7777, 0, 1);
    for (int n = 0; n < 5; n++) drive(0, 16'h0040, 16'h4000 + 16'(n), 0, 0);

    // Stall and flush together, then a stalled flush drain
    drive(0, 16'h0050, 16'h9999, 1, 1);
    drive(0, 16'h0050, 16'h8888, 0, 0);
    drive(0, 16'h0060, 16'h1111, 0, 1);
    drive(0, 16'h0060, 16'h2222, 1, 0);
    drive(0, 16'h0060, 16'h2222, 1, 0);
    for (int n = 0; n < 4; n++) drive(0, 16'h0060, 16'h3333, 0, 0);

    // Flush during drain restarts it; reset mid-flush
    drive(0, 16'h0070, 16'h0001, 0, 1);
    drive(0, 16'h0070, 16'h0002, 0, 0);
    drive(0, 16'h0070, 16'h0003, 0, 1);
    drive(0, 16'h0070, 16'h0004, 0, 0);
    drive(1, 16'h0070, 16'h0005, 0, 0);
    drive(0, 16'h0080, 16'hCAFE, 0, 0);
    chk("post_reset_capture", 2, 32'(o_valid[2]), 32'd1);

    // PC wrap
    drive(0, 16'hFFFF, 16'hBEEF, 0, 0);
    chk("pc_wrap", 0, 32'(o_pc[0]), 32'h0000);

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      drive(($urandom_range(0, 99) < 1), 16'($urandom), 16'($urandom),
            ($urandom_range(0, 99) < 25), ($urandom_range(0, 99) < 10));
    end

    // fetch_count wrap: 65535 fetches from reset, then one more
    drive(1, 16'h0000, 16'h0000, 0, 0);
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    for (int n = 0; n < 65534; n++) begin
      pc = 16'(n); instr = 16'(n ^ 16'h5A5A);
      cycle(1'b0);
    end
    drive(0, 16'h1000, 16'h2000, 0, 0);
    chk("count_ffff", 1, 32'(o_cnt[1]), 32'hFFFF);
    drive(0, 16'h1001, 16'h2001, 0, 0);
    chk("count_wrap", 2, 32'(o_cnt[2]), 32'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
